// File: rtl/jt51_slot_pkg.sv
// Shared definitions for the host-visible per-slot delay ring.
package jt51_slot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } slot_state_t;

    // Smallest address width that can count 0..n-1 (at least 1 bit).
    function automatic int slot_aw(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/jt51_sh_ring.sv
// Per-bit recirculating shift ring; the head input is chosen by the parent.
module jt51_sh_ring #(
    parameter int width  = 5,
    parameter int stages = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [width-1:0] din,
    output logic [width-1:0] drop
);

    for (genvar i = 0; i < width; i++) begin : g_bit
        logic [stages-1:0] sr;

        // Shift one bit-plane of the ring on every advance strobe.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                sr <= '0;
            else if (clk_en)
                sr <= {sr[stages-2:0], din[i]};
        end

        assign drop[i] = sr[stages-1];
    end

endmodule

// File: rtl/jt51_slot_port.sv
// Host read/write port into a per-slot delay ring. The slot counter names
// the slot currently at the ring tail (drop) and head (insert point).
module jt51_slot_port
    import jt51_slot_pkg::*;
#(
    parameter int width  = 5,
    parameter int stages = 32,
    parameter int aw     = slot_aw(stages)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [width-1:0] din,
    input  logic             din_valid,
    output logic [width-1:0] drop,
    output logic [aw-1:0]    cur_slot,
    input  logic             req,
    input  logic             we,
    input  logic [aw-1:0]    addr,
    input  logic [width-1:0] wdata,
    output logic             busy,
    output logic             ack,
    output logic [width-1:0] rdata
);

    slot_state_t      state;
    logic             we_q;
    logic [aw-1:0]    addr_q;
    logic [width-1:0] wdata_q;
    logic             hit;
    logic [width-1:0] ins;

    // The addressed slot is at the head while a request is pending.
    assign hit = (state == ST_WAIT) && (cur_slot == addr_q);

    // Head insert priority: host write, then pipeline data, then recirculate.
    always_comb begin
        ins = drop;
        if (hit && we_q)
            ins = wdata_q;
        else if (din_valid)
            ins = din;
    end

    jt51_sh_ring #(
        .width  (width),
        .stages (stages)
    ) u_ring (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .din    (ins),
        .drop   (drop)
    );

    // Slot counter with an explicit wrap so any ring depth works.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cur_slot <= '0;
        else if (clk_en) begin
            if (cur_slot == aw'(stages - 1))
                cur_slot <= '0;
            else
                cur_slot <= cur_slot + 1'b1;
        end
    end

    // Request handshake: latch, wait for the slot to come round, pulse ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            ack     <= 1'b0;
            rdata   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack <= 1'b0;
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (clk_en && hit) begin
                        // Reads capture the tail before this cycle's insert.
                        if (!we_q)
                            rdata <= drop;
                        ack   <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
